fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 157 +++++++++++++++
 tb/tb_fetch_queue.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue
//
// Instruction fetch queue sitting between the fetch stage and a two-wide
// decode stage. Fetch offers groups of up to four 32-bit instructions. Each
// valid slot is stored as one {inst, pc} entry in a circular buffer of DEPTH
// entries. Decode sees the oldest two entries every cycle.
//
// Handshake semantics (both sides):
//   Fetch side : a group transfers on a rising edge where fq_valid_i and
//                fq_ready_o are both 1. fq_ready_o depends only on registered
//                occupancy and flush_i, never on fq_valid_i. A group is
//                accepted whole or not at all. When ready is low the offer
//                is ignored, and fetch must hold or re-offer it.
//   Decode side: dec0/dec1 are presented whenever their valid is 1. When
//                dec_ready_i is 1, every valid dec output is consumed at
//                that edge, and none is consumed otherwise.
//
// Parameters
//   DEPTH        queue entries (power of two, >= 4)
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset; dominates everything
//   fq_valid_i   fetch group offered
//   fq_pc_i      PC of slot 0
//   fq_count_i   valid slots in the group (0 = empty group, 1..4)
//   fq_inst_i    four 32-bit slots, slot k at [32k+31:32k]
//   fq_ready_o   room for a full four-wide group and no flush this cycle
//   flush_i      redirect: drop all queued instructions
//   dec0_*       entry at head   (valid / inst / pc)
//   dec1_*       entry at head+1 (valid / inst / pc)
//   dec_ready_i  decode consumes all valid dec outputs this cycle
//   fq_used_o    occupancy, 0..DEPTH

module fetch_queue #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fq_valid_i,
    input  logic [63:0]                fq_pc_i,
    input  logic [2:0]                 fq_count_i,
    input  logic [127:0]               fq_inst_i,
    output logic                       fq_ready_o,
    input  logic                       flush_i,
    output logic                       dec0_valid_o,
    output logic [31:0]                dec0_inst_o,
    output logic [63:0]                dec0_pc_o,
    output logic                       dec1_valid_o,
    output logic [31:0]                dec1_inst_o,
    output logic [63:0]                dec1_pc_o,
    input  logic                       dec_ready_i,
    output logic [$clog2(DEPTH):0]     fq_used_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] GROUP_C = CNT_W'(4);

    // Entry storage, split into two arrays so each field has its own width.
    logic [31:0] inst_mem [DEPTH];
    logic [63:0] pc_mem   [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] used;

    logic [CNT_W-1:0] free_cnt;
    logic             enq_fire;
    logic [2:0]       count_eff;
    logic [2:0]       enq_n;
    logic [1:0]       deq_n;
    logic [PTR_W-1:0] head_p1;

    // ------------------------------------------------------------------
    // Fetch side
    // ------------------------------------------------------------------
    // Free space is measured from registered occupancy, before the dequeue
    // of the same cycle. This keeps fq_ready_o free of any path through
    // dec_ready_i or fq_valid_i. Slots freed by this cycle's dequeue become
    // usable next cycle.
    assign free_cnt   = DEPTH_C - used;
    assign fq_ready_o = (free_cnt >= GROUP_C) && !flush_i;
    assign enq_fire   = fq_valid_i && fq_ready_o;

    // Counts above four cannot describe a real group. Clamp them so that the
    // structural bound on occupancy (ready needs four free entries) holds.
    assign count_eff = (fq_count_i > 3'd4) ? 3'd4 : fq_count_i;
    assign enq_n     = enq_fire ? count_eff : 3'd0;

    // ------------------------------------------------------------------
    // Decode side
    // ------------------------------------------------------------------
    assign head_p1      = head + PTR_W'(1);
    assign dec0_valid_o = (used >= CNT_W'(1));
    assign dec1_valid_o = (used >= CNT_W'(2));

    always_comb begin
        dec0_inst_o = '0;
        dec0_pc_o   = '0;
        dec1_inst_o = '0;
        dec1_pc_o   = '0;
        if (dec0_valid_o) begin
            dec0_inst_o = inst_mem[head];
            dec0_pc_o   = pc_mem[head];
        end
        if (dec1_valid_o) begin
            dec1_inst_o = inst_mem[head_p1];
            dec1_pc_o   = pc_mem[head_p1];
        end
    end

    assign deq_n = dec_ready_i ? ({1'b0, dec0_valid_o} + {1'b0, dec1_valid_o}) : 2'd0;

    assign fq_used_o = used;

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    // Head and tail move independently. Pointer arithmetic is PTR_W bits
    // wide, so the modulo-DEPTH wrap is free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            head <= '0;
            tail <= '0;
            used <= '0;
        end else begin
            head <= head + PTR_W'(deq_n);
            tail <= tail + PTR_W'(enq_n);
            used <= used + CNT_W'(enq_n) - CNT_W'(deq_n);
        end
    end

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    // Slot k of an accepted group lands at tail+k with pc = fq_pc_i + 4k.
    // Slots at or beyond the group count are left untouched. A flush only
    // resets the pointers. Stale entries are unreachable because used = 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (enq_fire) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < count_eff) begin
                    inst_mem[tail + PTR_W'(k)] <= fq_inst_i[32*k +: 32];
                    pc_mem[tail + PTR_W'(k)]   <= fq_pc_i + 64'(4 * k);
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int DEPTH = 8;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic         clk = 1'b0;
    logic         rst;
    logic         fq_valid_i;
    logic [63:0]  fq_pc_i;
    logic [2:0]   fq_count_i;
    logic [127:0] fq_inst_i;
    logic         fq_ready_o;
    logic         flush_i;
    logic         dec0_valid_o;
    logic [31:0]  dec0_inst_o;
    logic [63:0]  dec0_pc_o;
    logic         dec1_valid_o;
    logic [31:0]  dec1_inst_o;
    logic [63:0]  dec1_pc_o;
    logic         dec_ready_i;
    logic [3:0]   fq_used_o;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .fq_valid_i   (fq_valid_i),
        .fq_pc_i      (fq_pc_i),
        .fq_count_i   (fq_count_i),
        .fq_inst_i    (fq_inst_i),
        .fq_ready_o   (fq_ready_o),
        .flush_i      (flush_i),
        .dec0_valid_o (dec0_valid_o),
        .dec0_inst_o  (dec0_inst_o),
        .dec0_pc_o    (dec0_pc_o),
        .dec1_valid_o (dec1_valid_o),
        .dec1_inst_o  (dec1_inst_o),
        .dec1_pc_o    (dec1_pc_o),
        .dec_ready_i  (dec_ready_i),
        .fq_used_o    (fq_used_o)
    );

    // ------------------------------------------------------------------
    // Scoreboard: one {inst, pc} per queued instruction, oldest first
    // ------------------------------------------------------------------
    logic [95:0]  exp_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [127:0] inst_in;
    logic         last_acc;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_idle();
        fq_valid_i  = 1'b0;
        fq_pc_i     = '0;
        fq_count_i  = '0;
        fq_inst_i   = '0;
        dec_ready_i = 1'b0;
        flush_i     = 1'b0;
        rst         = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Driver: one cycle. Called just after a falling edge. Drives inputs,
    // compares outputs with the model, advances the model for the coming
    // edge, then returns after the next falling edge with inputs idle.
    // ------------------------------------------------------------------
    task automatic step(input logic v, input logic [63:0] pc, input logic [2:0] cnt,
                        input logic dr, input logic fl, input logic r);
        logic        exp_ready;
        logic [95:0] e0;
        logic [95:0] e1;
        int          deq_n;
        fq_valid_i  = v;
        fq_pc_i     = pc;
        fq_count_i  = cnt;
        fq_inst_i   = inst_in;
        dec_ready_i = dr;
        flush_i     = fl;
        rst         = r;
        #1;
        exp_ready = ((DEPTH - exp_q.size()) >= 4) && !fl;
        e0 = (exp_q.size() >= 1) ? exp_q[0] : '0;
        e1 = (exp_q.size() >= 2) ? exp_q[1] : '0;
        check("dec0_valid", dec0_valid_o, exp_q.size() >= 1);
        check("dec1_valid", dec1_valid_o, exp_q.size() >= 2);
        check("dec0_entry", {dec0_inst_o, dec0_pc_o}, e0);
        check("dec1_entry", {dec1_inst_o, dec1_pc_o}, e1);
        check("fq_ready", fq_ready_o, exp_ready);
        check("fq_used", fq_used_o, exp_q.size());

        last_acc = v && exp_ready && !r;
        if (r || fl) begin
            exp_q.delete();
        end else begin
            deq_n = dr ? ((exp_q.size() >= 2) ? 2 : exp_q.size()) : 0;
            repeat (deq_n) void'(exp_q.pop_front());
            if (last_acc) begin
                for (int k = 0; k < 4; k++) begin
                    if (k < int'(cnt)) exp_q.push_back({inst_in[32*k +: 32], pc + 64'(4 * k)});
                end
            end
        end
        @(posedge clk);
        #1;
        set_idle();
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH && exp_q.size() != 0; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [63:0] pc;
        set_idle();
        inst_in = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);

        check("rst_dec0_valid", dec0_valid_o, 1'b0);
        check("rst_dec1_valid", dec1_valid_o, 1'b0);
        check("rst_dec0_pc", dec0_pc_o, 64'd0);
        check("rst_dec0_inst", dec0_inst_o, 32'd0);
        check("rst_used", fq_used_o, 4'd0);
        check("rst_ready", fq_ready_o, 1'b1);

        // Basic four-wide group, decode stalled.
        inst_in = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        step(1'b1, 64'h8000_0000, 3'd4, 1'b0, 1'b0, 1'b0);
        check("basic_dec0_pc", dec0_pc_o, 64'h8000_0000);
        check("basic_dec0_inst", dec0_inst_o, 32'hAAAA_0001);
        check("basic_dec1_pc", dec1_pc_o, 64'h8000_0004);
        check("basic_dec1_inst", dec1_inst_o, 32'hBBBB_0002);
        check("basic_used", fq_used_o, 4'd4);
        drain();

        // Partial group: only slot 0 stored.
        inst_in = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        step(1'b1, 64'h8000_000C, 3'd1, 1'b0, 1'b0, 1'b0);
        check("part_used", fq_used_o, 4'd1);
        check("part_dec0_pc", dec0_pc_o, 64'h8000_000C);
        check("part_dec0_inst", dec0_inst_o, 32'h4444_4444);
        check("part_dec1_valid", dec1_valid_o, 1'b0);
        check("part_dec1_pc", dec1_pc_o, 64'd0);
        check("part_dec1_inst", dec1_inst_o, 32'd0);
        drain();

        // Empty group (count 0) stores nothing.
        step(1'b1, 64'h9000_0000, 3'd0, 1'b0, 1'b0, 1'b0);
        check("empty_used", fq_used_o, 4'd0);

        // Full and backpressure.
        inst_in = {$urandom, $urandom, $urandom, $urandom};
        step(1'b1, 64'h1000, 3'd4, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h1010, 3'd4, 1'b0, 1'b0, 1'b0);
        check("full_used", fq_used_o, 4'd8);
        check("full_ready", fq_ready_o, 1'b0);
        step(1'b1, 64'h2000, 3'd4, 1'b0, 1'b0, 1'b0);
        check("full_drop_used", fq_used_o, 4'd8);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check("full_deq1_used", fq_used_o, 4'd6);
        check("full_deq1_ready", fq_ready_o, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check("full_deq2_used", fq_used_o, 4'd4);
        check("full_deq2_ready", fq_ready_o, 1'b1);
        drain();

        // Wrap with simultaneous enqueue and dequeue; the PC advances only
        // when the model says the group was taken.
        pc = 64'h3000;
        for (int i = 0; i < 10; i++) begin
            inst_in = {$urandom, $urandom, $urandom, $urandom};
            step(1'b1, pc, 3'd4, 1'b1, 1'b0, 1'b0);
            if (last_acc) pc = pc + 64'd16;
        end
        drain();

        // PC carry out of bit 63 is discarded.
        inst_in = {$urandom, $urandom, $urandom, $urandom};
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 3'd4, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check("carry_dec0_pc", dec0_pc_o, 64'h0);
        check("carry_dec1_pc", dec1_pc_o, 64'h4);
        drain();

        // Flush with a competing enqueue and dequeue.
        step(1'b1, 64'h4000, 3'd4, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h4010, 3'd4, 1'b1, 1'b0, 1'b0);
        check("pre_flush_used", fq_used_o, 4'd6);
        step(1'b1, 64'h5000, 3'd4, 1'b1, 1'b1, 1'b0);
        check("flush_used", fq_used_o, 4'd0);
        check("flush_dec0_valid", dec0_valid_o, 1'b0);
        check("flush_dec1_valid", dec1_valid_o, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("flush_after_used", fq_used_o, 4'd0);

        // Reset mid-stream with a competing enqueue.
        step(1'b1, 64'h6000, 3'd4, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h6010, 3'd1, 1'b0, 1'b0, 1'b0);
        check("pre_rst_used", fq_used_o, 4'd5);
        step(1'b1, 64'h7000, 3'd4, 1'b1, 1'b0, 1'b1);
        check("mrst_used", fq_used_o, 4'd0);
        check("mrst_dec0_valid", dec0_valid_o, 1'b0);
        check("mrst_dec1_valid", dec1_valid_o, 1'b0);
        check("mrst_dec0_pc", dec0_pc_o, 64'd0);
        check("mrst_dec1_inst", dec1_inst_o, 32'd0);
        check("mrst_ready", fq_ready_o, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            inst_in = {$urandom, $urandom, $urandom, $urandom};
            step(($urandom_range(0, 3) != 0), {$urandom, $urandom} & ~64'h3,
                 3'($urandom_range(0, 4)), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 40) == 0), ($urandom_range(0, 80) == 0));
        end
        drain();
        check("final_used", fq_used_o, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
